sha256_msg_schedule: RTL and testbench
======================================

// Module: sha256_msg_schedule
// PURPOSE
//  SHA-256 message-schedule expander. Sits directly upstream of the compression core in
//  MOD_SHA256.
//  - Accepts one padded 512-bit block as 16 big-endian 32-bit words.
//  - Emits W[0..63] in order, one word per handshake, to the round logic.
//  - The round logic combines W[t] with K[t] from hk_mem.
// PARAMETERS
//  (none; word width fixed at 32, block length fixed at 16 words, round count fixed at 64)
// PORTS
//  CLK        in   1   clock, all state updates on rising edge
//  RST_N      in   1   reset, asynchronous assert, active-low
//  CLEAR      in   1   synchronous abort; returns block to LOAD, discards the current block
//  IN_VALID   in   1   IN_WORD valid
//  IN_READY   out  1   block accepts a message word
//  IN_WORD    in   32  message word M[i], i = 0..15 in arrival order
//  OUT_VALID  out  1   OUT_WORD holds W[OUT_INDEX]
//  OUT_READY  in   1   consumer takes OUT_WORD this cycle
//  OUT_WORD   out  32  schedule word W[t]
//  OUT_INDEX  out  6   t, 0..63
//  OUT_LAST   out  1   OUT_VALID && OUT_INDEX==63
// BEHAVIOUR
//  Reset (RST_N=0, async):
//   - state=LOAD, load count=0, t=0, window[0..15]=0.
//   - IN_READY=1 once RST_N=1; OUT_VALID=0, OUT_WORD=0, OUT_INDEX=0, OUT_LAST=0.
//  Storage:
//   - 16x32 sliding window; window[i] holds W[t+i].
//   - 4-bit load counter; 6-bit round counter t.
//  State LOAD:
//   - IN_READY=1, OUT_VALID=0.
//   - On IN_VALID&&IN_READY: window[cnt] <= IN_WORD; cnt++.
//   - On the 16th handshake (cnt==15): next state=EXPAND, t=0.
//   - OUT_VALID=1 in the following cycle (1-cycle latency from the last word accepted).
//  State EXPAND:
//   - IN_READY=0, OUT_VALID=1, OUT_WORD=window[0], OUT_INDEX=t.
//   - On OUT_VALID&&OUT_READY:
//     - shift window down by one (window[i] <= window[i+1]);
//     - window[15] <= s1(window[14]) + window[9] + s0(window[1]) + window[0];
//     - t++.
//   - Handshake with t==63: next state=LOAD, cnt=0.
//     - IN_READY=1 the next cycle.
//     - No idle cycle is required between blocks.
//  Arithmetic:
//   - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
//   - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
//   - Sums are mod 2^32; carries are discarded.
//   - Words computed after W[63] are never emitted, so they are don't-care.
//  Backpressure:
//   - While OUT_VALID && !OUT_READY, OUT_WORD, OUT_INDEX and OUT_LAST hold stable.
//   - The window does not change.
//  Input stalls: with IN_VALID=0 in LOAD, nothing changes; gaps between words are allowed.
//  CLEAR=1 (any state, sync):
//   - next state=LOAD, cnt=0, t=0, OUT_VALID=0 next cycle.
//   - Window contents are don't-care; they are overwritten by the next load.
//   - CLEAR takes priority over any handshake in the same cycle; that word is dropped.
//  Reset mid-LOAD or mid-EXPAND:
//   - The partial block is discarded.
//   - The first IN_WORD accepted after release is M[0].
//  OUT_INDEX never wraps past 63 within a block; t returns to 0 only via the LOAD transition.
// TESTING
//  1 Reset: RST_N=0 with random inputs -> IN_READY=1 after release; OUT_VALID=0,
//    OUT_WORD=0, OUT_INDEX=0.
//  2 "abc" block: M0=0x61626380, M1..M14=0, M15=0x00000018, OUT_READY=1 ->
//    W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
//    All 64 words match a C model; OUT_LAST only at t=63.
//  3 Backpressure: same block, OUT_READY random 50% -> identical W sequence.
//    Output is stable in every stalled cycle; exactly 64 handshakes.
//  4 Back-to-back: two random blocks, IN_VALID=1 continuously ->
//    IN_READY=1 the cycle after the W63 handshake.
//    Second block's 64 words match the model; no word is lost or duplicated.
//  5 CLEAR at t=20, then at load cnt=7 -> OUT_VALID=0 next cycle.
//    Next full 16-word load expands correctly from W0.
//  6 RST_N pulsed low mid-EXPAND (t=40), asynchronous to CLK -> outputs reach reset
//    values without waiting for a clock edge.
//    A following fresh block expands correctly.

Source files
------------

// File: rtl/sha256_msg_schedule_if.sv
// sha256_msg_schedule_if: message-word input and schedule-word output handshakes
interface sha256_msg_schedule_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_index;
  logic        out_last;
  modport master (output in_valid, in_word, out_ready,
                  input  in_ready, out_valid, out_word, out_index, out_last);
  modport slave  (input  in_valid, in_word, out_ready,
                  output in_ready, out_valid, out_word, out_index, out_last);
endinterface

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: loads 16 message words, then streams W[0..63] from a sliding window
module sha256_msg_schedule (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   clear,
  sha256_msg_schedule_if.slave  bus
);
  typedef enum logic {LOAD, EXPAND} state_t;
  state_t      state, nxt;
  logic [31:0] win [16];
  logic [3:0]  cnt;
  logic [5:0]  t;
  logic        in_hs, out_hs;
  logic [31:0] s0, s1, w_new;
  assign s0    = {win[1][6:0], win[1][31:7]} ^ {win[1][17:0], win[1][31:18]} ^ (win[1] >> 3);
  assign s1    = {win[14][16:0], win[14][31:17]} ^ {win[14][18:0], win[14][31:19]} ^ (win[14] >> 10);
  assign w_new = s1 + win[9] + s0 + win[0];
  assign bus.in_ready  = state == LOAD;
  assign bus.out_valid = state == EXPAND;
  assign bus.out_word  = bus.out_valid ? win[0] : '0;
  assign bus.out_index = t;
  assign bus.out_last  = bus.out_valid && t == 6'd63;
  assign in_hs  = bus.in_valid && bus.in_ready;
  assign out_hs = bus.out_valid && bus.out_ready;
  always_comb begin
    nxt = state;
    if (clear) nxt = LOAD;
    else if (in_hs && cnt == 4'd15) nxt = EXPAND;
    else if (out_hs && t == 6'd63) nxt = LOAD;
  end
  // cnt and t both wrap to 0 naturally at the end of load and expand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      t     <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      state <= nxt;
      if (clear) begin
        cnt <= '0;
        t   <= '0;
      end else if (in_hs) begin
        win[cnt] <= bus.in_word;
        cnt      <= cnt + 4'd1;
        t        <= '0;
      end else if (out_hs) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_new;
        t       <= t + 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: directed checks of the SHA-256 message schedule expander
module tb_sha256_msg_schedule;
  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sch_t [64];
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  int   errors = 0, checks = 0;
  blk_t abc;
  sch_t abc_w;
  sha256_msg_schedule_if ifc ();
  sha256_msg_schedule dut (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifc.slave));
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic model(input blk_t m, output sch_t w);
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
  endtask

  task automatic rand_blk(output blk_t m);
    for (int i = 0; i < 16; i++) m[i] = $urandom;
  endtask

  task automatic load_block(input blk_t m, input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_word  = m[i];
      c = 0;
      while (!ifc.in_ready && c < 200) begin
        @(posedge clk); #1;
        c++;
      end
      if (c == 200) begin
        errors++;
        $display("FAIL load_wait: in_ready=%b want 1 at word %0d", ifc.in_ready, i);
      end
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic expect_block(input sch_t w, input int n, input int pct);
    int k, cyc;
    logic stalled, sl;
    logic [31:0] sw;
    logic [5:0] si;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 3000) begin
      ifc.out_ready = ($urandom_range(99) < pct);
      stalled = 1'b0;
      if (ifc.out_valid) begin
        if (ifc.out_ready) begin
          checks += 3;
          if (ifc.out_index !== 6'(k)) begin
            errors++;
            $display("FAIL out_index: got %0d want %0d", ifc.out_index, k);
          end
          if (ifc.out_word !== w[k]) begin
            errors++;
            $display("FAIL out_word[%0d]: got %h want %h", k, ifc.out_word, w[k]);
          end
          if (ifc.out_last !== (k == 63)) begin
            errors++;
            $display("FAIL out_last[%0d]: got %b want %b", k, ifc.out_last, k == 63);
          end
          k++;
        end else begin
          stalled = 1'b1;
          sw = ifc.out_word;
          si = ifc.out_index;
          sl = ifc.out_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (stalled) begin
        checks++;
        if ({ifc.out_valid, ifc.out_word, ifc.out_index, ifc.out_last} !== {1'b1, sw, si, sl}) begin
          errors++;
          $display("FAIL stall_stable: got %b/%h/%0d/%b want 1/%h/%0d/%b",
                   ifc.out_valid, ifc.out_word, ifc.out_index, ifc.out_last, sw, si, sl);
        end
      end
    end
    ifc.out_ready = 1'b0;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL handshakes: got %0d want %0d", k, n);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      ifc.in_valid  = $urandom_range(1);
      ifc.in_word   = $urandom;
      ifc.out_ready = $urandom_range(1);
      clear         = $urandom_range(1);
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b0;
    clear = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks += 4;
    if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
    if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
    if (ifc.out_word !== 32'h0) begin errors++; $display("FAIL reset_out_word: got %h want 0", ifc.out_word); end
    if (ifc.out_index !== 6'd0) begin errors++; $display("FAIL reset_out_index: got %0d want 0", ifc.out_index); end
  endtask

  task automatic test_abc;
    load_block(abc, 16);
    checks += 2;
    if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL abc_latency: out_valid=%b want 1", ifc.out_valid); end
    if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL abc_in_ready: got %b want 0", ifc.in_ready); end
    expect_block(abc_w, 64, 100);
    checks++;
    if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL abc_done: out_valid=%b want 0", ifc.out_valid); end
  endtask

  task automatic test_backpressure;
    load_block(abc, 16);
    expect_block(abc_w, 64, 50);
    checks += 2;
    if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra: out_valid=%b want 0", ifc.out_valid); end
    if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready: got %b want 1", ifc.in_ready); end
  endtask

  task automatic test_back_to_back;
    blk_t a, b;
    sch_t wa, wb;
    rand_blk(a);
    rand_blk(b);
    model(a, wa);
    model(b, wb);
    load_block(a, 16);
    ifc.in_valid = 1'b1;
    ifc.in_word  = b[0];
    expect_block(wa, 64, 100);
    checks++;
    if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", ifc.in_ready); end
    load_block(b, 16);
    expect_block(wb, 64, 100);
  endtask

  task automatic test_clear;
    blk_t m;
    sch_t w;
    load_block(abc, 16);
    expect_block(abc_w, 20, 100);
    clear = 1'b1;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    ifc.out_ready = 1'b0;
    checks += 2;
    if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL clear_expand: out_valid=%b want 0", ifc.out_valid); end
    if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_ready: got %b want 1", ifc.in_ready); end
    rand_blk(m);
    model(m, w);
    load_block(abc, 7);
    clear = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_word = 32'hdeadbeef;
    @(posedge clk); #1;
    clear = 1'b0;
    ifc.in_valid = 1'b0;
    checks++;
    if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL clear_load: out_valid=%b want 0", ifc.out_valid); end
    load_block(m, 15);
    checks++;
    if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL clear_cnt: out_valid=%b after 15 words want 0", ifc.out_valid); end
    ifc.in_valid = 1'b1;
    ifc.in_word = m[15];
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    expect_block(w, 64, 100);
  endtask

  task automatic test_async_reset;
    blk_t m;
    sch_t w;
    rand_blk(m);
    model(m, w);
    load_block(m, 16);
    expect_block(w, 40, 100);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", ifc.out_valid); end
    if (ifc.out_word !== 32'h0) begin errors++; $display("FAIL arst_out_word: got %h want 0", ifc.out_word); end
    if (ifc.out_index !== 6'd0) begin errors++; $display("FAIL arst_out_index: got %0d want 0", ifc.out_index); end
    if (ifc.out_last !== 1'b0) begin errors++; $display("FAIL arst_out_last: got %b want 0", ifc.out_last); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rand_blk(m);
    model(m, w);
    load_block(m, 16);
    expect_block(w, 64, 100);
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_word = '0;
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) abc[i] = 32'h0;
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;
    model(abc, abc_w);
    checks += 4;
    if (abc_w[0] !== 32'h61626380) begin errors++; $display("FAIL model_w0: got %h want 61626380", abc_w[0]); end
    if (abc_w[15] !== 32'h00000018) begin errors++; $display("FAIL model_w15: got %h want 00000018", abc_w[15]); end
    if (abc_w[16] !== 32'h61626380) begin errors++; $display("FAIL model_w16: got %h want 61626380", abc_w[16]); end
    if (abc_w[17] !== 32'h000f0000) begin errors++; $display("FAIL model_w17: got %h want 000f0000", abc_w[17]); end
    test_reset();
    test_abc();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
